// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared constants, FSM encoding and frame-check helper for the PS/2 keyboard receiver.
`timescale 1ns/1ps
package ps2_keyboard_rx_pkg;

  // Prefix bytes folded into the is_break / is_extended flags
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // Receiver frame states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // A frame is good when data plus parity has odd weight and the stop bit is high
  function automatic logic frame_ok(input logic [7:0] data, input logic parity,
                                    input logic stop);
    return (^{data, parity}) & stop;
  endfunction

endpackage

// File: rtl/ps2_keyboard_rx_line_filter.sv
// 2-FF synchronizer, run-length glitch filter and falling-edge strobe for the PS/2 clock line.
`timescale 1ns/1ps
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic line,
  output logic filtered,
  output logic fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

  logic          meta;
  logic          synced;
  logic [CW-1:0] cnt;

  // Synchronize, then let the filtered level follow only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      meta     <= 1'b1;
      synced   <= 1'b1;
      filtered <= 1'b1;
      cnt      <= '0;
      fall     <= 1'b0;
    end else begin
      meta   <= line;
      synced <= meta;
      fall   <= 1'b0;
      if (synced == filtered) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        filtered <= synced;
        cnt      <= '0;
        fall     <= filtered;  // filtered is still 1 here only on a 1->0 change
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: deframes 11-bit frames and emits scan codes with break/extended flags.
`timescale 1ns/1ps
module ps2_keyboard_rx
  import ps2_keyboard_rx_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       is_break,
  output logic       is_extended,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

  logic fall;
  logic clk_filt;
  logic data_meta;
  logic data_sync;

  ps2_state_e    state,        state_nxt;
  logic [7:0]    shift,        shift_nxt;
  logic [2:0]    bit_cnt,      bit_cnt_nxt;
  logic          parity,       parity_nxt;
  logic [TW-1:0] to_cnt,       to_cnt_nxt;
  logic          brk_pend,     brk_pend_nxt;
  logic          ext_pend,     ext_pend_nxt;
  logic [7:0]    code_nxt;
  logic          valid_nxt;
  logic          brk_nxt;
  logic          ext_nxt;
  logic          err_nxt;
  logic          timeout;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk      (clk),
    .reset    (reset),
    .line     (ps2_clk),
    .filtered (clk_filt),
    .fall     (fall)
  );

  // Data line only needs synchronizing; it is sampled well after it settles, on the clock fall
  always_ff @(posedge clk) begin
    if (reset) begin
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      shift       <= '0;
      bit_cnt     <= '0;
      parity      <= 1'b0;
      to_cnt      <= '0;
      brk_pend    <= 1'b0;
      ext_pend    <= 1'b0;
      scan_code   <= '0;
      scan_valid  <= 1'b0;
      is_break    <= 1'b0;
      is_extended <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      shift       <= shift_nxt;
      bit_cnt     <= bit_cnt_nxt;
      parity      <= parity_nxt;
      to_cnt      <= to_cnt_nxt;
      brk_pend    <= brk_pend_nxt;
      ext_pend    <= ext_pend_nxt;
      scan_code   <= code_nxt;
      scan_valid  <= valid_nxt;
      is_break    <= brk_nxt;
      is_extended <= ext_nxt;
      frame_err   <= err_nxt;
    end
  end

  assign timeout = (state != ST_IDLE) && (to_cnt == TO_MAX);
  assign busy    = (state != ST_IDLE);

  // Next-state, deframing, prefix folding and timeout abort
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case can infer a latch.
    state_nxt    = state;
    shift_nxt    = shift;
    bit_cnt_nxt  = bit_cnt;
    parity_nxt   = parity;
    brk_pend_nxt = brk_pend;
    ext_pend_nxt = ext_pend;
    code_nxt     = scan_code;
    brk_nxt      = is_break;
    ext_nxt      = is_extended;
    valid_nxt    = 1'b0;
    err_nxt      = 1'b0;

    // Timeout counter: cleared by any fall or while idle, otherwise counts up and saturates
    if (fall || state == ST_IDLE) begin
      to_cnt_nxt = '0;
    end else if (to_cnt != TO_MAX) begin
      to_cnt_nxt = to_cnt + 1'b1;
    end else begin
      to_cnt_nxt = to_cnt;
    end

    if (timeout) begin
      state_nxt    = ST_IDLE;
      err_nxt      = 1'b1;
      brk_pend_nxt = 1'b0;
      ext_pend_nxt = 1'b0;
      to_cnt_nxt   = '0;
    end else if (fall) begin
      unique case (state)
        ST_IDLE: begin
          if (!data_sync) begin
            state_nxt   = ST_DATA;
            bit_cnt_nxt = '0;
          end
        end
        ST_DATA: begin
          shift_nxt   = {data_sync, shift[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
        end
        ST_PARITY: begin
          parity_nxt = data_sync;
          state_nxt  = ST_STOP;
        end
        ST_STOP: begin
          state_nxt = ST_IDLE;
          if (!frame_ok(shift, parity, data_sync)) begin
            err_nxt      = 1'b1;
            brk_pend_nxt = 1'b0;
            ext_pend_nxt = 1'b0;
          end else if (shift == PS2_BREAK) begin
            brk_pend_nxt = 1'b1;
          end else if (shift == PS2_EXT) begin
            ext_pend_nxt = 1'b1;
          end else begin
            code_nxt     = shift;
            brk_nxt      = brk_pend;
            ext_nxt      = ext_pend;
            valid_nxt    = 1'b1;
            brk_pend_nxt = 1'b0;
            ext_pend_nxt = 1'b0;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed testbench for ps2_keyboard_rx: device-side frame generator plus pulse monitor.
`timescale 1ns/1ps
module tb_ps2_keyboard_rx;

  // Device bit clock scaled by 1/100 (400 ns half-period) with the timeout scaled to match
  // (200 cycles = 2.5 bit periods, as 200 us is against a 40 us half-period).
  localparam int HALF_NS = 400;
  localparam int TO_CYC  = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       is_break;
  logic       is_extended;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int failures = 0;

  int         n_valid = 0;
  int         n_err = 0;
  int         n_both = 0;
  logic [7:0] last_code = '0;
  logic       last_brk = 1'b0;
  logic       last_ext = 1'b0;

  always #5 clk = ~clk;

  ps2_keyboard_rx #(
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .scan_code   (scan_code),
    .scan_valid  (scan_valid),
    .is_break    (is_break),
    .is_extended (is_extended),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  // Pulse monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (scan_valid) begin
      n_valid   = n_valid + 1;
      last_code = scan_code;
      last_brk  = is_break;
      last_ext  = is_extended;
    end
    if (frame_err) n_err = n_err + 1;
    if (scan_valid && frame_err) n_both = n_both + 1;
  end

  // Drive nbits of a frame LSB first; data changes mid-way through the high phase
  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      #(HALF_NS / 2);
      ps2_data = bits[i];
      #(HALF_NS / 2);
      ps2_clk = 1'b0;
      #(HALF_NS);
      ps2_clk = 1'b1;
    end
    #(HALF_NS / 2);
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic p);
    send_bits({1'b1, p, b, 1'b0}, 11);
    #(HALF_NS * 2);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({scan_code, scan_valid, is_break, is_extended, frame_err, busy} !== 13'd0) begin
      failures++;
      $display("FAIL reset_outputs: got code=%h v=%b b=%b e=%b err=%b busy=%b, want all 0",
               scan_code, scan_valid, is_break, is_extended, frame_err, busy);
    end
    reset = 1'b0;
    repeat (20) @(posedge clk);
  endtask

  task automatic test_single_make;
    int bv = n_valid;
    int be = n_err;
    send_frame(8'h1D, 1'b1);
    checks++;
    if (n_valid - bv !== 1) begin
      failures++; $display("FAIL make_count: got %0d scan_valid, want 1", n_valid - bv);
    end
    checks++;
    if (last_code !== 8'h1D) begin
      failures++; $display("FAIL make_code: got %h, want 1d", last_code);
    end
    checks++;
    if ({last_brk, last_ext} !== 2'b00) begin
      failures++; $display("FAIL make_flags: got brk=%b ext=%b, want 0 0", last_brk, last_ext);
    end
    checks++;
    if (n_err - be !== 0) begin
      failures++; $display("FAIL make_err: got %0d frame_err, want 0", n_err - be);
    end
  endtask

  task automatic test_break;
    int bv = n_valid;
    send_frame(8'hF0, 1'b1);
    send_frame(8'h1D, 1'b1);
    checks++;
    if (n_valid - bv !== 1) begin
      failures++; $display("FAIL break_count: got %0d scan_valid, want 1", n_valid - bv);
    end
    checks++;
    if ({last_code, last_brk, last_ext} !== {8'h1D, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL break_decode: got code=%h brk=%b ext=%b, want 1d 1 0", last_code, last_brk, last_ext);
    end
    send_frame(8'h1D, 1'b1);
    checks++;
    if (n_valid - bv !== 2) begin
      failures++; $display("FAIL break_follow_count: got %0d scan_valid, want 2", n_valid - bv);
    end
    checks++;
    if ({last_code, last_brk} !== {8'h1D, 1'b0}) begin
      failures++; $display("FAIL break_cleared: got code=%h brk=%b, want 1d 0", last_code, last_brk);
    end
  endtask

  task automatic test_extended_break;
    int bv = n_valid;
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b1);
    send_frame(8'h75, 1'b0);
    checks++;
    if (n_valid - bv !== 1) begin
      failures++; $display("FAIL ext_count: got %0d scan_valid, want 1", n_valid - bv);
    end
    checks++;
    if ({last_code, last_brk, last_ext} !== {8'h75, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL ext_decode: got code=%h brk=%b ext=%b, want 75 1 1", last_code, last_brk, last_ext);
    end
  endtask

  task automatic test_parity_error;
    int bv = n_valid;
    int be = n_err;
    send_frame(8'h1D, 1'b0);
    checks++;
    if (n_err - be !== 1) begin
      failures++; $display("FAIL parity_err: got %0d frame_err, want 1", n_err - be);
    end
    checks++;
    if (n_valid - bv !== 0) begin
      failures++; $display("FAIL parity_novalid: got %0d scan_valid, want 0", n_valid - bv);
    end
    send_frame(8'h1C, 1'b0);
    checks++;
    if ({last_code, last_brk, last_ext} !== {8'h1C, 1'b0, 1'b0} || n_valid - bv !== 1) begin
      failures++;
      $display("FAIL parity_recover: got code=%h brk=%b ext=%b valids=%0d, want 1c 0 0 1",
               last_code, last_brk, last_ext, n_valid - bv);
    end
  endtask

  task automatic test_timeout;
    int bv = n_valid;
    int be = n_err;
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 4);  // start + 3 data bits, returns 600 ns after last fall
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL timeout_busy_mid: got busy=%b, want 1", busy);
    end
    #900;  // 150 cycles after last fall: still short of the timeout
    checks++;
    if (n_err - be !== 0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_early: got err=%0d busy=%b, want 0 1", n_err - be, busy);
    end
    #1600;  // 310 cycles after last fall: well past the timeout
    checks++;
    if (n_err - be !== 1) begin
      failures++; $display("FAIL timeout_err: got %0d frame_err, want 1", n_err - be);
    end
    checks++;
    if (busy !== 1'b0 || n_valid - bv !== 0) begin
      failures++;
      $display("FAIL timeout_idle: got busy=%b valids=%0d, want 0 0", busy, n_valid - bv);
    end
    send_frame(8'h1C, 1'b0);
    checks++;
    if (last_code !== 8'h1C || n_valid - bv !== 1 || n_err - be !== 1) begin
      failures++;
      $display("FAIL timeout_recover: got code=%h valids=%0d errs=%0d, want 1c 1 1",
               last_code, n_valid - bv, n_err - be);
    end
  endtask

  task automatic test_glitch_and_reset;
    int   bv = n_valid;
    int   be = n_err;
    logic saw_busy = 1'b0;
    @(posedge clk); #1;
    ps2_clk = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    ps2_clk = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
    checks++;
    if (saw_busy !== 1'b0 || n_valid - bv !== 0 || n_err - be !== 0) begin
      failures++;
      $display("FAIL glitch_ignored: got busy_seen=%b valids=%0d errs=%0d, want 0 0 0",
               saw_busy, n_valid - bv, n_err - be);
    end
    send_bits({1'b1, 1'b0, 8'h29, 1'b0}, 5);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({scan_code, scan_valid, is_break, is_extended, frame_err, busy} !== 13'd0) begin
      failures++;
      $display("FAIL midframe_reset: got code=%h v=%b b=%b e=%b err=%b busy=%b, want all 0",
               scan_code, scan_valid, is_break, is_extended, frame_err, busy);
    end
    #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    bv = n_valid;
    be = n_err;
    send_frame(8'h29, 1'b0);
    checks++;
    if ({last_code, last_brk, last_ext} !== {8'h29, 1'b0, 1'b0} || n_valid - bv !== 1 || n_err - be !== 0) begin
      failures++;
      $display("FAIL reset_recover: got code=%h brk=%b ext=%b valids=%0d errs=%0d, want 29 0 0 1 0",
               last_code, last_brk, last_ext, n_valid - bv, n_err - be);
    end
  endtask

  initial begin
    test_reset;
    test_single_make;
    test_break;
    test_extended_break;
    test_parity_error;
    test_timeout;
    test_glitch_and_reset;
    checks++;
    if (n_both !== 0) begin
      failures++; $display("FAIL exclusive_pulses: got %0d overlapping cycles, want 0", n_both);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case a task never returns
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
